// File: rtl/feed_sched_pkg.sv
// Shared definitions for the feed scheduler: FSM encoding and width helper.
package feed_sched_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fs_state_e;

  // Bits needed to hold 0..v-1, never less than one so a 1-entry range still has a wire.
  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/feed_sched_rr_arbiter.sv
// Circular priority pick: first eligible requester at or after ptr wins.
module feed_sched_rr_arbiter
  import feed_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  // Walk the ring starting at ptr; the first hit locks out the rest.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && eligible[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          win[i] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/feed_sched.sv
// Write arbiter + fixed-cadence read scheduler for one shared ring buffer.
// Occupancy lives here; the buffer itself trusts these strobes blindly.
module feed_sched
  import feed_sched_pkg::*;
#(
  parameter int WORDLEN     = 8,
  parameter int DEPTH       = 16,
  parameter int NREQ        = 4,
  parameter int RD_INTERVAL = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WORDLEN-1:0] req_data,
  output logic [NREQ-1:0]         gnt,
  output logic                    buf_write,
  output logic [WORDLEN-1:0]      buf_din,
  output logic                    buf_read,
  output logic                    rd_valid,
  input  logic                    drain_en,
  input  logic                    flush,
  output logic [4:0]              count,
  output logic                    full,
  output logic                    empty,
  output logic                    busy
);

  localparam int             PW        = clog2_min1(NREQ);
  localparam int             TW        = clog2_min1(RD_INTERVAL);
  localparam logic [TW-1:0]  TICK_LAST = TW'(RD_INTERVAL - 1);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(NREQ - 1);
  localparam logic [4:0]     DEPTH_C   = 5'(DEPTH);

  fs_state_e            state_q;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [4:0]           count_q, count_d, count_nw;
  logic [NREQ-1:0]      gnt_q;
  logic                 wr_q, rd_q, rv_q, full_q, empty_q;
  logic [WORDLEN-1:0]   din_q;

  logic [NREQ-1:0]      eligible, win;
  logic                 any, rd_fire, wr_fire;
  logic [PW-1:0]        w_idx;
  logic [WORDLEN-1:0]   w_data;

  // A requester whose grant is visible this cycle has not yet dropped req; mask it.
  assign eligible = req & ~gnt_q;

  feed_sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .win      (win),
    .any      (any)
  );

  // Reads only see committed occupancy, so a word being written now is not readable yet.
  assign rd_fire  = (state_q != FS_IDLE) && (tick_q == TICK_LAST) &&
                    (drain_en || (state_q == FS_FLUSH)) && (count_q != 5'd0);
  // A read issued this cycle frees a slot for a write on the same edge.
  assign count_nw = count_q - {4'd0, rd_fire};
  // The flush cycle itself already refuses new words.
  assign wr_fire  = (state_q == FS_RUN) && !flush && any && (count_nw < DEPTH_C);
  assign count_d  = count_nw + {4'd0, wr_fire};

  // Turn the one-hot winner into an index and its data word.
  always_comb begin
    w_idx  = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        w_idx  = PW'(i);
        w_data = req_data[i*WORDLEN +: WORDLEN];
      end
    end
  end

  assign ptr_d  = wr_fire ? ((w_idx == PTR_LAST) ? '0 : w_idx + PW'(1)) : ptr_q;
  // Parked at zero while idle, so each entry to RUN starts a fresh interval.
  assign tick_d = (state_q == FS_IDLE) ? '0 :
                  ((tick_q == TICK_LAST) ? '0 : tick_q + TW'(1));

  // Control FSM: IDLE waits for work, RUN arbitrates and drains, FLUSH only drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
    end else begin
      case (state_q)
        FS_IDLE:  if (req != '0) state_q <= FS_RUN;
        FS_RUN: begin
          if (flush)
            state_q <= FS_FLUSH;
          else if ((count_q == 5'd0) && (req == '0) && !wr_q && !rd_q)
            state_q <= FS_IDLE;
        end
        FS_FLUSH: if ((count_q == 5'd0) && !rd_q) state_q <= FS_IDLE;
        default:  state_q <= FS_IDLE;
      endcase
    end
  end

  // Pointer, cadence counter, occupancy and all registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      tick_q  <= '0;
      count_q <= 5'd0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      rv_q    <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      gnt_q   <= win & {NREQ{wr_fire}};
      wr_q    <= wr_fire;
      if (wr_fire) din_q <= w_data;
      rd_q    <= rd_fire;
      rv_q    <= rd_q;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == 5'd0);
    end
  end

  assign gnt       = gnt_q;
  assign buf_write = wr_q;
  assign buf_din   = din_q;
  assign buf_read  = rd_q;
  assign rd_valid  = rv_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign busy      = (state_q != FS_IDLE);

  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
  a_count_nowrap: assert property (@(posedge clk) disable iff (rst)
    !(rd_fire && (count_q == 5'd0)));

endmodule

// File: tb/tb_feed_sched.sv
// Bench for feed_sched: queue-based occupancy model with random producers,
// plus a second instance with RD_INTERVAL=1 for the fast-cadence case.
module tb_feed_sched;
  localparam int WL = 8, DEPTH = 16, NREQ = 4, RD = 8;
  localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // RD_INTERVAL=8 instance
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*WL-1:0] req_data = '0;
  logic drain_en = 1'b0, flush = 1'b0;
  logic [NREQ-1:0] gnt;
  logic buf_write, buf_read, rd_valid, full, empty, busy;
  logic [WL-1:0] buf_din;
  logic [4:0] count;

  feed_sched #(.WORDLEN(WL), .DEPTH(DEPTH), .NREQ(NREQ), .RD_INTERVAL(RD)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .buf_write(buf_write), .buf_din(buf_din), .buf_read(buf_read), .rd_valid(rd_valid),
    .drain_en(drain_en), .flush(flush), .count(count), .full(full), .empty(empty), .busy(busy));

  // RD_INTERVAL=1 instance
  logic [NREQ-1:0]    req1 = '0;
  logic [NREQ*WL-1:0] req_data1 = '0;
  logic drain1 = 1'b0, flush1 = 1'b0;
  logic [NREQ-1:0] gnt1;
  logic buf_write1, buf_read1, rd_valid1, full1, empty1, busy1;
  logic [WL-1:0] buf_din1;
  logic [4:0] count1;

  feed_sched #(.WORDLEN(WL), .DEPTH(DEPTH), .NREQ(NREQ), .RD_INTERVAL(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .gnt(gnt1),
    .buf_write(buf_write1), .buf_din(buf_din1), .buf_read(buf_read1), .rd_valid(rd_valid1),
    .drain_en(drain1), .flush(flush1), .count(count1), .full(full1), .empty(empty1), .busy(busy1));

  int n_checks = 0;
  int n_fail   = 0;

  // Producers: words remaining and the word currently offered.
  int         pend  [NREQ];
  logic [7:0] pdata [NREQ];

  // Reference model: buffer contents as a queue, plus the visible strobes.
  int         m_state, m_ptr, m_tick;
  logic [7:0] m_q[$];
  logic [3:0] m_gnt;
  bit         m_wr, m_rd, m_rv;
  logic [7:0] m_din;
  int         n_state, n_ptr, n_tick;
  logic [3:0] n_gnt;
  bit         n_wr, n_rd, n_rv;
  logic [7:0] n_din;

  task automatic m_reset();
    m_state = S_IDLE; m_ptr = 0; m_tick = 0; m_q.delete();
    m_gnt = '0; m_wr = 0; m_rd = 0; m_rv = 0; m_din = '0;
  endtask

  task automatic model_eval();
    int sz, w;
    logic [3:0] el;
    bit rd;
    sz = m_q.size();
    el = req & ~m_gnt;
    rd = (m_state != S_IDLE) && (m_tick == RD - 1) &&
         (drain_en || m_state == S_FLUSH) && (sz > 0);
    w = -1;
    if (m_state == S_RUN && !flush && el != 0 && (sz - int'(rd)) < DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && el[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    n_wr  = (w >= 0);
    n_gnt = n_wr ? (4'b0001 << w) : 4'b0000;
    n_din = n_wr ? req_data[w*WL +: WL] : m_din;
    n_rd  = rd;
    n_rv  = m_rd;
    n_ptr = n_wr ? (w + 1) % NREQ : m_ptr;
    n_tick = (m_state == S_IDLE) ? 0 : (m_tick + 1) % RD;
    n_state = m_state;
    case (m_state)
      S_IDLE:  if (req != 0) n_state = S_RUN;
      S_RUN:   if (flush) n_state = S_FLUSH;
               else if (sz == 0 && req == 0 && !m_wr && !m_rd) n_state = S_IDLE;
      default: if (sz == 0 && !m_rd) n_state = S_IDLE;
    endcase
  endtask

  task automatic model_commit();
    if (n_wr) m_q.push_back(n_din);
    if (n_rd) void'(m_q.pop_front());
    m_state = n_state; m_ptr = n_ptr; m_tick = n_tick;
    m_gnt = n_gnt; m_wr = n_wr; m_rd = n_rd; m_rv = n_rv; m_din = n_din;
  endtask

  function automatic logic [22:0] exp_vec();
    int sz;
    sz = m_q.size();
    return {m_gnt, m_wr, (m_wr ? m_din : 8'h00), m_rd, m_rv, 5'(sz),
            (sz == DEPTH), (sz == 0), (m_state != S_IDLE)};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {gnt, buf_write, (buf_write ? buf_din : 8'h00), buf_read, rd_valid, count,
            full, empty, busy};
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (pend[i] > 0);
      req_data[i*WL +: WL] = pdata[i];
    end
  endtask

  // One clock: model sees the same inputs as the DUT, producers react to gnt afterwards.
  task automatic step();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] && pend[i] > 0) begin
        pend[i]--;
        pdata[i] = 8'($urandom);
      end
    drive_req();
  endtask

  task automatic hard_reset();
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pdata[i] = 8'($urandom); end
    drive_req();
    flush = 0; drain_en = 0; req1 = '0;
    #2 rst = 1;
    m_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1000; pdata[i] = 8'($urandom); end
    drive_req();
    m_reset();
    #12;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_values obs=%h exp=%h", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_burst c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({gnt, buf_write, buf_read, rd_valid, count, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset obs=%b exp=0", {gnt, buf_write, buf_read, rd_valid, count, busy});
    end
    hard_reset();
  endtask

  task automatic test_fill();
    int gseq;
    gseq = 0;
    hard_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1000;
    drive_req();
    for (int c = 0; c < 24; c++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL fill c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (gnt != 0) begin
        n_checks++;
        if (gnt !== 4'(1 << (gseq % NREQ))) begin
          n_fail++; $display("FAIL fill_order g%0d obs=%b exp=%0d", gseq, gnt, gseq % NREQ);
        end
        gseq++;
      end
    end
    n_checks++;
    if ({count, full, gseq[4:0]} !== {5'd16, 1'b1, 5'd16}) begin
      n_fail++; $display("FAIL fill_full count=%0d full=%b grants=%0d exp 16/1/16", count, full, gseq);
    end
  endtask

  task automatic test_drain_full();
    int nrd;
    nrd = 0;
    drain_en = 1;
    for (int c = 0; c < 48; c++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || count < 15) begin
        n_fail++; $display("FAIL drain_full c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (buf_read) nrd++;
    end
    n_checks++;
    if (nrd != 6) begin n_fail++; $display("FAIL drain_full_reads obs=%0d exp=6", nrd); end
  endtask

  task automatic test_single();
    int nwr;
    bit prev;
    nwr = 0; prev = 0;
    hard_reset();
    pend[2] = 3;
    drive_req();
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || (prev && gnt[2])) begin
        n_fail++; $display("FAIL single c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      prev = gnt[2];
      if (buf_write) nwr++;
    end
    n_checks++;
    if ({nwr[4:0], count} !== {5'd3, 5'd3}) begin
      n_fail++; $display("FAIL single_total writes=%0d count=%0d exp 3/3", nwr, count);
    end
  endtask

  task automatic test_flush();
    int nrd, last, bad_gap, ngnt;
    nrd = 0; last = -1; bad_gap = 0; ngnt = 0;
    hard_reset();
    pend[0] = 5;
    drive_req();
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush_fill c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre count=%0d exp=5", count); end
    pend[0] = 50; pend[1] = 50;
    drive_req();
    flush = 1;
    step();
    flush = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 3) begin pend[0] = 0; pend[1] = 0; drive_req(); end
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL flush c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (gnt != 0) ngnt++;
      if (buf_read) begin
        if (last >= 0 && c - last != RD) bad_gap++;
        last = c; nrd++;
      end
    end
    n_checks++;
    if ({nrd[3:0], bad_gap[3:0], ngnt[3:0], busy, count} !== {4'd5, 4'd0, 4'd0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL flush_end reads=%0d badgaps=%0d gnts=%0d busy=%b count=%0d exp 5/0/0/0/0",
               nrd, bad_gap, ngnt, busy, count);
    end
  endtask

  task automatic test_random();
    hard_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = $urandom_range(1, 4);
      drain_en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 60) == 0);
      drive_req();
      step();
      flush = 0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_rate1();
    hard_reset();
    req1 = 4'b0001; req_data1 = 32'h0000_00A5; drain1 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy1, buf_write1} !== 2'b10) begin
      n_fail++; $display("FAIL rate1_e1 busy/wr=%b exp=10", {busy1, buf_write1});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({gnt1, buf_write1, buf_din1, count1, buf_read1} !== {4'b0001, 1'b1, 8'hA5, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL rate1_write obs=%h", {gnt1, buf_write1, buf_din1, count1, buf_read1});
    end
    req1 = 4'b0000;
    @(posedge clk); #1;
    n_checks++;
    if ({buf_read1, count1, rd_valid1} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL rate1_read rd=%b count=%0d rv=%b exp 1/0/0", buf_read1, count1, rd_valid1);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rd_valid1, buf_read1, empty1} !== 3'b101) begin
      n_fail++; $display("FAIL rate1_valid rv/rd/empty=%b exp=101", {rd_valid1, buf_read1, empty1});
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rate1_idle busy=%b exp=0", busy1); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_full();
    test_single();
    test_flush();
    test_random();
    test_rate1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
